// File: rtl/gate_quiz_ctrl_pkg.sv
// Shared constants and types for the gate quiz controller: gate indices,
// controller states and the LFSR feedback taps.
package gate_quiz_pkg;

   localparam logic [3:0] GATE_AND  = 4'd0;
   localparam logic [3:0] GATE_OR   = 4'd1;
   localparam logic [3:0] GATE_NAND = 4'd2;
   localparam logic [3:0] GATE_NOR  = 4'd3;
   localparam logic [3:0] GATE_XOR  = 4'd4;
   localparam logic [3:0] GATE_XNOR = 4'd5;
   localparam logic [3:0] GATE_SR   = 4'd6;
   localparam logic [3:0] GATE_T    = 4'd7;
   localparam logic [3:0] GATE_D    = 4'd8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PICK,
      ST_PLAY,
      ST_BLANK,
      ST_DONE
   } state_t;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/gate_quiz_ctrl_if.sv
// Player-side and display-side signal bundle of the gate quiz controller.
// The front end / bench drives through master; the controller uses slave.
interface gate_quiz_ctrl_if #(
   parameter int NUM_GATES = 9,
   parameter int TIME_W    = 32,
   parameter int MISS_W    = 8
);
   logic                 in_a;
   logic                 in_b;
   logic                 switch_pulse;
   logic                 confirm_pulse;
   logic                 gate_out;
   logic [NUM_GATES-1:0] selected_gate;
   logic [NUM_GATES-1:0] current_gate;
   logic [NUM_GATES-1:0] completed_mask;
   logic                 timer_en;
   logic                 vga_blankout;
   logic                 done;
   logic                 timeout;
   logic [TIME_W-1:0]    elapsed;
   logic [MISS_W-1:0]    miss_count;

   modport master (
      output in_a, in_b, switch_pulse, confirm_pulse,
      input  gate_out, selected_gate, current_gate, completed_mask,
      input  timer_en, vga_blankout, done, timeout, elapsed, miss_count
   );

   modport slave (
      input  in_a, in_b, switch_pulse, confirm_pulse,
      output gate_out, selected_gate, current_gate, completed_mask,
      output timer_en, vga_blankout, done, timeout, elapsed, miss_count
   );
endinterface

// File: rtl/gate_quiz_eval.sv
// Evaluates the hidden gate on the synchronised player wires; holds the
// SR / T / D storage and registers the result.
module gate_quiz_eval
   import gate_quiz_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       i_a,
   input  logic       i_b,
   input  logic [3:0] i_gate,
   input  logic       i_clear,
   output logic       o_gate_out
);
   logic r_sr_q, r_t_q, r_d_q, r_b_prev, r_gate_out;
   logic w_sr_next, w_t_next, w_d_next, w_gate;

   // Reset input dominates the SR latch
   assign w_sr_next = i_b ? 1'b0 : (i_a ? 1'b1 : r_sr_q);
   assign w_t_next  = (i_a && i_b && !r_b_prev) ? ~r_t_q : r_t_q;
   assign w_d_next  = i_b ? i_a : r_d_q;

   always_comb begin
      w_gate = 1'b0;
      case (i_gate)
         GATE_AND:  w_gate = i_a & i_b;
         GATE_OR:   w_gate = i_a | i_b;
         GATE_NAND: w_gate = ~(i_a & i_b);
         GATE_NOR:  w_gate = ~(i_a | i_b);
         GATE_XOR:  w_gate = i_a ^ i_b;
         GATE_XNOR: w_gate = ~(i_a ^ i_b);
         GATE_SR:   w_gate = w_sr_next;
         GATE_T:    w_gate = w_t_next;
         GATE_D:    w_gate = w_d_next;
         default:   w_gate = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sr_q     <= 1'b0;
         r_t_q      <= 1'b0;
         r_d_q      <= 1'b0;
         r_b_prev   <= 1'b0;
         r_gate_out <= 1'b0;
      end else begin
         r_b_prev <= i_b;
         if (i_clear) begin
            r_sr_q     <= 1'b0;
            r_t_q      <= 1'b0;
            r_d_q      <= 1'b0;
            r_gate_out <= 1'b0;
         end else begin
            r_sr_q     <= w_sr_next;
            r_t_q      <= w_t_next;
            r_d_q      <= w_d_next;
            r_gate_out <= w_gate;
         end
      end
   end

   assign o_gate_out = r_gate_out;
endmodule

// File: rtl/gate_quiz_ctrl.sv
// Gate quiz controller: random gate pick, guess checking, miss blank-out and timing.
// Optional time limit (TIME_LIMIT parameter) is enabled by defining GATE_QUIZ_TIME_LIMIT_EN.
module gate_quiz_ctrl
   import gate_quiz_pkg::*;
#(
   parameter int          NUM_GATES    = 9,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1,
   parameter int          BLANK_CYCLES = 25_000_000,
   parameter int          TIME_W       = 32,
   parameter int          MISS_W       = 8
`ifdef GATE_QUIZ_TIME_LIMIT_EN
   ,
   parameter logic [31:0] TIME_LIMIT   = 32'd1_500_000_000
`endif
) (
   input  logic             clk,
   input  logic             resetn,
   gate_quiz_ctrl_if.slave  bus
);
   localparam int         BLANK_W  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [4:0] NG5      = 5'(NUM_GATES);
   localparam logic [3:0] LAST_IDX = 4'(NUM_GATES - 1);

   state_t               r_state;
   logic [15:0]          r_lfsr;
   logic                 r_a_meta, r_a_sync, r_b_meta, r_b_sync;
   logic [NUM_GATES-1:0] r_sel, r_cur, r_mask;
   logic [3:0]           r_cur_idx, r_cand;
   logic [BLANK_W-1:0]   r_blank_cnt;
   logic [TIME_W-1:0]    r_elapsed;
   logic [MISS_W-1:0]    r_miss;
   logic                 r_timer_en, r_blankout, r_done, r_timeout;

   logic [3:0]           w_cand_init;
   logic [NUM_GATES-1:0] w_cand_oh, w_sel_rot;
   logic                 w_cand_free, w_time_up, w_eval_clear, w_gate_out;

   assign w_cand_init  = ({1'b0, r_lfsr[3:0]} >= NG5) ? 4'd0 : r_lfsr[3:0];
   assign w_cand_oh    = NUM_GATES'(1) << r_cand;
   assign w_cand_free  = ~|(r_mask & w_cand_oh);
   assign w_sel_rot    = (r_sel << 1) | (r_sel >> (NUM_GATES - 1));
   assign w_eval_clear = (r_state == ST_IDLE) || (r_state == ST_PICK);

`ifdef GATE_QUIZ_TIME_LIMIT_EN
   assign w_time_up = r_timer_en && (r_elapsed == TIME_W'(TIME_LIMIT - 32'd1));
`else
   assign w_time_up = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_lfsr   <= LFSR_SEED;
         r_a_meta <= 1'b0;
         r_a_sync <= 1'b0;
         r_b_meta <= 1'b0;
         r_b_sync <= 1'b0;
         r_sel    <= NUM_GATES'(1);
      end else begin
         r_lfsr   <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
         r_a_meta <= bus.in_a;
         r_a_sync <= r_a_meta;
         r_b_meta <= bus.in_b;
         r_b_sync <= r_b_meta;
         if (bus.switch_pulse) r_sel <= w_sel_rot;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= ST_IDLE;
         r_cur       <= '0;
         r_cur_idx   <= '0;
         r_cand      <= '0;
         r_mask      <= '0;
         r_blank_cnt <= '0;
         r_elapsed   <= '0;
         r_miss      <= '0;
         r_timer_en  <= 1'b0;
         r_blankout  <= 1'b0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         if (r_timer_en && (r_elapsed != '1)) r_elapsed <= r_elapsed + 1'b1;
         // The time limit outranks a confirm arriving in the same cycle
         if (w_time_up) begin
            r_state    <= ST_DONE;
            r_timer_en <= 1'b0;
            r_blankout <= 1'b0;
            r_done     <= 1'b1;
            r_timeout  <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE: if (bus.confirm_pulse) begin
                  r_state    <= ST_PICK;
                  r_elapsed  <= '0;
                  r_miss     <= '0;
                  r_timer_en <= 1'b1;
                  r_cand     <= w_cand_init;
               end
               ST_PICK: if (w_cand_free) begin
                  r_state   <= ST_PLAY;
                  r_cur     <= w_cand_oh;
                  r_cur_idx <= r_cand;
               end else begin
                  r_cand <= (r_cand == LAST_IDX) ? 4'd0 : r_cand + 4'd1;
               end
               ST_PLAY: if (bus.confirm_pulse) begin
                  if (r_sel == r_cur) begin
                     r_mask <= r_mask | r_cur;
                     if ((r_mask | r_cur) == '1) begin
                        r_state    <= ST_DONE;
                        r_timer_en <= 1'b0;
                        r_done     <= 1'b1;
                     end else begin
                        r_state <= ST_PICK;
                        r_cur   <= '0;
                        r_cand  <= w_cand_init;
                     end
                  end else begin
                     if (r_miss != '1) r_miss <= r_miss + 1'b1;
                     r_state     <= ST_BLANK;
                     r_blankout  <= 1'b1;
                     r_blank_cnt <= '0;
                  end
               end
               ST_BLANK: if (r_blank_cnt == BLANK_W'(BLANK_CYCLES - 1)) begin
                  r_state    <= ST_PLAY;
                  r_blankout <= 1'b0;
               end else begin
                  r_blank_cnt <= r_blank_cnt + 1'b1;
               end
               ST_DONE: if (bus.confirm_pulse) begin
                  r_state    <= ST_PICK;
                  r_mask     <= '0;
                  r_elapsed  <= '0;
                  r_miss     <= '0;
                  r_cur      <= '0;
                  r_done     <= 1'b0;
                  r_timeout  <= 1'b0;
                  r_timer_en <= 1'b1;
                  r_cand     <= w_cand_init;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   gate_quiz_eval u_eval (
      .clk        (clk),
      .resetn     (resetn),
      .i_a        (r_a_sync),
      .i_b        (r_b_sync),
      .i_gate     (r_cur_idx),
      .i_clear    (w_eval_clear),
      .o_gate_out (w_gate_out)
   );

   assign bus.gate_out       = w_gate_out;
   assign bus.selected_gate  = r_sel;
   assign bus.current_gate   = r_cur;
   assign bus.completed_mask = r_mask;
   assign bus.timer_en       = r_timer_en;
   assign bus.vga_blankout   = r_blankout;
   assign bus.done           = r_done;
   assign bus.timeout        = r_timeout;
   assign bus.elapsed        = r_elapsed;
   assign bus.miss_count     = r_miss;
endmodule

// File: tb/tb_gate_quiz_ctrl.sv
// Randomised self-checking bench for gate_quiz_ctrl against a turn-level
// reference model (selection, pick scan, mask, misses, elapsed time, gate truth).
module tb_gate_quiz_ctrl;
   localparam int NG = 9;
   localparam int BC = 4;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   logic [15:0] m_lfsr;

   logic [NG-1:0] m_mask, m_sel;
   int   m_cur, m_miss, e0, e_conf, turns;
   logic [15:0] l_conf;
   logic m_q, m_pb, game_done;

   gate_quiz_ctrl_if #(.NUM_GATES(NG)) bus();

   gate_quiz_ctrl #(.NUM_GATES(NG), .BLANK_CYCLES(BC)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) m_lfsr <= 16'hACE1;
      else         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h required=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [NG-1:0] onehot(input int idx);
      logic [NG-1:0] v;
      v = 1;
      return v << idx;
   endfunction

   function automatic logic [NG-1:0] rot(input logic [NG-1:0] s);
      return s[NG-1] ? onehot(0) : (s << 1);
   endfunction

   task automatic switch_once();
      bus.switch_pulse = 1'b1;
      @(negedge clk);
      bus.switch_pulse = 1'b0;
      m_sel = rot(m_sel);
   endtask

   task automatic confirm(input bit with_switch);
      bus.confirm_pulse = 1'b1;
      bus.switch_pulse  = with_switch;
      e_conf = cyc;
      l_conf = m_lfsr;
      @(negedge clk);
      bus.confirm_pulse = 1'b0;
      bus.switch_pulse  = 1'b0;
   endtask

   // Hold a/b long enough to settle through the synchroniser, then check the gate truth
   task automatic apply_step(input logic a, input logic b);
      logic e;
      bus.in_a = a;
      bus.in_b = b;
      repeat (4) @(negedge clk);
      case (m_cur)
         0: e = a & b;
         1: e = a | b;
         2: e = ~(a & b);
         3: e = ~(a | b);
         4: e = a ^ b;
         5: e = ~(a ^ b);
         6: begin if (b) m_q = 1'b0; else if (a) m_q = 1'b1; e = m_q; end
         7: begin if (a && b && !m_pb) m_q = ~m_q; e = m_q; end
         default: begin if (b) m_q = a; e = m_q; end
      endcase
      m_pb = b;
      check_val($sformatf("gate_out g%0d a%0d b%0d", m_cur, a, b), 64'(bus.gate_out), 64'(e));
   endtask

   task automatic expect_pick();
      int c, skips, n;
      c = int'(l_conf[3:0]);
      if (c >= NG) c = 0;
      skips = 0;
      while (m_mask[c]) begin
         c = (c + 1) % NG;
         skips++;
      end
      check_val("pick_entry_cur", 64'(bus.current_gate), 64'(0));
      n = 0;
      while (bus.current_gate == 0 && n < NG + 3) begin
         @(negedge clk);
         n++;
      end
      check_val("pick_cycles", 64'(n), 64'(skips + 1));
      check_val("pick_gate", 64'(bus.current_gate), 64'(onehot(c)));
      check_val("pick_timer_en", 64'(bus.timer_en), 64'(1));
      m_cur = c;
      m_q   = 1'b0;
      m_pb  = 1'b0;
   endtask

   task automatic play_turn();
      int target, cnt;
      bit correct, combine, hit;
      logic [63:0] el;
      apply_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      apply_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      apply_step(1'b0, 1'b0);
      correct = ($urandom_range(0, 3) != 0);
      combine = ($urandom_range(0, 3) == 0);
      target  = correct ? m_cur : (m_cur + 1 + int'($urandom_range(0, NG - 2))) % NG;
      for (int k = 0; k < NG && m_sel != onehot(target); k++) switch_once();
      check_val("sel_before", 64'(bus.selected_gate), 64'(m_sel));
      hit = (m_sel == onehot(m_cur));
      confirm(combine);
      if (combine) m_sel = rot(m_sel);
      $display("turn %0d: gate=%0d guess=%0d hit=%0d switch_too=%0d", turns, m_cur, target, hit, combine);
      if (hit) begin
         m_mask = m_mask | onehot(m_cur);
         if (m_mask == '1) begin
            game_done = 1'b1;
            check_val("done_flag", 64'(bus.done), 64'(1));
            check_val("done_timer_en", 64'(bus.timer_en), 64'(0));
            check_val("done_mask", 64'(bus.completed_mask), 64'(m_mask));
            check_val("done_elapsed", 64'(bus.elapsed), 64'(e_conf - e0));
            check_val("done_miss", 64'(bus.miss_count), 64'(m_miss));
            check_val("done_timeout", 64'(bus.timeout), 64'(0));
            el = 64'(e_conf - e0);
            repeat (3) @(negedge clk);
            check_val("done_elapsed_frozen", 64'(bus.elapsed), el);
            check_val("done_cur_held", 64'(bus.current_gate), 64'(onehot(m_cur)));
         end else begin
            check_val("hit_mask", 64'(bus.completed_mask), 64'(m_mask));
            expect_pick();
         end
      end else begin
         m_miss++;
         cnt = 0;
         while (bus.vga_blankout && cnt < BC + 5) begin
            bus.confirm_pulse = (cnt == 1);
            cnt++;
            @(negedge clk);
         end
         bus.confirm_pulse = 1'b0;
         check_val("blank_len", 64'(cnt), 64'(BC));
         check_val("miss_count", 64'(bus.miss_count), 64'(m_miss));
         check_val("blank_back_cur", 64'(bus.current_gate), 64'(onehot(m_cur)));
         check_val("blank_back_timer", 64'(bus.timer_en), 64'(1));
      end
      check_val("sel_after", 64'(bus.selected_gate), 64'(m_sel));
      turns++;
   endtask

   task automatic restart_game();
      confirm(1'b0);
      m_mask = '0;
      m_miss = 0;
      e0 = e_conf;
      game_done = 1'b0;
      check_val("restart_mask", 64'(bus.completed_mask), 64'(0));
      check_val("restart_miss", 64'(bus.miss_count), 64'(0));
      check_val("restart_elapsed", 64'(bus.elapsed), 64'(0));
      check_val("restart_done", 64'(bus.done), 64'(0));
      expect_pick();
   endtask

   task automatic check_reset_values(input string pfx);
      check_val({pfx, "_sel"}, 64'(bus.selected_gate), 64'(1));
      check_val({pfx, "_cur"}, 64'(bus.current_gate), 64'(0));
      check_val({pfx, "_mask"}, 64'(bus.completed_mask), 64'(0));
      check_val({pfx, "_gate_out"}, 64'(bus.gate_out), 64'(0));
      check_val({pfx, "_timer_en"}, 64'(bus.timer_en), 64'(0));
      check_val({pfx, "_blank"}, 64'(bus.vga_blankout), 64'(0));
      check_val({pfx, "_done"}, 64'(bus.done), 64'(0));
      check_val({pfx, "_timeout"}, 64'(bus.timeout), 64'(0));
      check_val({pfx, "_elapsed"}, 64'(bus.elapsed), 64'(0));
      check_val({pfx, "_miss"}, 64'(bus.miss_count), 64'(0));
   endtask

   initial begin
      int n;
      bus.in_a = 1'b0;
      bus.in_b = 1'b0;
      bus.switch_pulse  = 1'b0;
      bus.confirm_pulse = 1'b0;
      m_sel = onehot(0);
      m_mask = '0;
      m_miss = 0;
      m_cur = 0;
      m_q = 1'b0;
      m_pb = 1'b0;
      turns = 0;
      game_done = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("rst");
      resetn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < NG; i++) begin
         switch_once();
         check_val($sformatf("walk_%0d", i), 64'(bus.selected_gate), 64'(m_sel));
      end
      check_val("walk_wrap", 64'(bus.selected_gate), 64'(1));

      n = 0;
      while (m_lfsr[3:0] != 4'd4 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_val("lfsr_cand4_found", 64'(m_lfsr[3:0]), 64'(4));
      confirm(1'b0);
      e0 = e_conf;
      $display("start: lfsr=%h", l_conf);
      expect_pick();
      check_val("start_gate", 64'(bus.current_gate), 64'(9'h010));

      bus.in_a = 1'b1;
      bus.in_b = 1'b0;
      repeat (2) @(negedge clk);
      check_val("xor_lat2", 64'(bus.gate_out), 64'(0));
      @(negedge clk);
      check_val("xor_lat3", 64'(bus.gate_out), 64'(1));
      bus.in_b = 1'b1;
      repeat (3) @(negedge clk);
      check_val("xor_11", 64'(bus.gate_out), 64'(0));
      apply_step(1'b0, 1'b0);

      while (!game_done && turns < 200) play_turn();
      check_val("game1_done", 64'(game_done), 64'(1));

      restart_game();
      while (!game_done && turns < 400) play_turn();
      check_val("game2_done", 64'(game_done), 64'(1));

      restart_game();
      for (int k = 0; k < NG && m_sel != onehot((m_cur + 1) % NG); k++) switch_once();
      confirm(1'b0);
      $display("turn %0d: gate=%0d guess=%0d hit=0 then reset in blank", turns, m_cur, (m_cur + 1) % NG);
      @(negedge clk);
      check_val("midblank_blank", 64'(bus.vga_blankout), 64'(1));
      #2 resetn = 1'b0;
      #1 check_reset_values("midblank_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/gate_quiz_ctrl.md
Name: gate_quiz_ctrl

Overview:
Synchronous, parametrised gate-identification game controller. Presents a hidden logic gate, chosen at random from the set of gates not yet completed, driven by two player input wires. The player cycles a one-hot selection and confirms a guess. Tracks completion, misses and elapsed time, and drives a VGA blank-out pulse on a miss. Sits between the key/switch edge-detect front end and the VGA/HEX display logic.

Parameters:
NUM_GATES, 9, number of gates in play (1..9); gate index order: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 SR latch, 7 T flip-flop, 8 D latch
LFSR_SEED, 16'hACE1, nonzero reset value of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
BLANK_CYCLES, 25_000_000, clk cycles vga_blankout is held after a miss (must be >= 1)
TIME_W, 32, elapsed-cycle counter width
MISS_W, 8, miss counter width

Ports:
clk  in  1  system clock (CLOCK_50)
resetn  in  1  asynchronous active-low reset
in_a  in  1  top player wire, asynchronous level
in_b  in  1  bottom player wire, asynchronous level
switch_pulse  in  1  one-cycle pulse: advance selection
confirm_pulse  in  1  one-cycle pulse: start game / confirm guess
gate_out  out  1  registered output of the current gate
selected_gate  out  NUM_GATES  one-hot player selection
current_gate  out  NUM_GATES  one-hot hidden gate (all-zero while IDLE/PICK)
completed_mask  out  NUM_GATES  bit i set once gate i has been guessed correctly
timer_en  out  1  high in PICK, PLAY and BLANK
vga_blankout  out  1  high in BLANK
done  out  1  high in DONE
timeout  out  1  high in DONE when entered via time limit
elapsed  out  TIME_W  cycles counted while timer_en; saturates at all-ones
miss_count  out  MISS_W  wrong confirms; saturates

Behaviour:
- Reset values: state IDLE, selected_gate = 1, current_gate = 0, completed_mask = 0, gate_out = 0, all flags 0, elapsed = 0, miss_count = 0, LFSR = LFSR_SEED, gate internal state = 0. A reset during operation aborts the game immediately.
- in_a and in_b pass through a 2-flop synchroniser. gate_out is registered one cycle after the synchronised inputs, so input-to-output latency is 3 cycles.
- Sequential gates are clocked by clk only:
  - SR: set on a, reset on b; b wins if both are high.
  - T: toggles on a rising edge of synchronised b while a = 1.
  - D: transparent (Q = a) while b = 1.
  - SR/T/D state clears on every PICK entry.
- LFSR advances every cycle, including in IDLE.
- switch_pulse rotates selected_gate left, wrapping from bit NUM_GATES-1 to bit 0. It is honoured in every state.
- States:
  - IDLE: confirm -> PICK; clear elapsed and miss_count.
  - PICK: cand = LFSR[3:0]; if cand >= NUM_GATES, cand = 0. Each cycle: if completed_mask[cand] = 0, load current_gate and go to PLAY; else cand = cand+1 (mod NUM_GATES). Worst case NUM_GATES+1 cycles.
  - PLAY: on confirm:
    - If selected_gate == current_gate: set the completed bit. If the mask becomes all ones -> DONE; else -> PICK.
    - Otherwise: miss_count++ and go to BLANK.
  - BLANK: counts BLANK_CYCLES, then returns to PLAY. Confirm is ignored.
  - DONE: timer frozen, current_gate held. Confirm clears completed_mask, elapsed and miss_count, then -> PICK.
- Simultaneous switch and confirm in one cycle: the compare uses selected_gate before rotation; the rotation is still applied.
- confirm_pulse held high for several cycles is treated as multiple confirms; the front end guarantees single-cycle pulses.

Optional Feature:
- Macro: GATE_QUIZ_TIME_LIMIT_EN.
- When defined: parameter TIME_LIMIT (default 32'd1_500_000_000) is added. When elapsed == TIME_LIMIT-1 in PICK, PLAY or BLANK, the next state is DONE with timeout = 1. This takes priority over a same-cycle confirm.
- When undefined: timeout is tied to 0 and the game ends only on completion.

Decomposition:
- Package gate_quiz_pkg holds:
  - gate index constants GATE_AND..GATE_D;
  - state enum typedef;
  - LFSR tap constant.
- Natural sub-module: gate_quiz_eval. Inputs: synchronised a/b, gate index and clear. Output: registered gate_out. It contains the SR/T/D state.

Test Plan:
- Reset, then switch_pulse x9 with NUM_GATES=9 -> selected_gate walks 1,2,4..256 and wraps to 1.
- Confirm from IDLE with LFSR forced so that cand=4 -> within 2 cycles current_gate=16, timer_en=1. Drive a=1,b=1 -> gate_out=0 three cycles later (XOR).
- Wrong confirm in PLAY with BLANK_CYCLES=4 -> vga_blankout high exactly 4 cycles, miss_count=1, confirm during BLANK ignored.
- completed_mask=9'h1EF (bit 4 clear), PICK entered with cand=7 -> scan wraps and lands on gate 4 within 7 cycles.
- Correct confirms for all NUM_GATES=3 gates -> done=1, timer_en=0, elapsed frozen; next confirm restarts with mask 0.
- With GATE_QUIZ_TIME_LIMIT_EN and TIME_LIMIT=50 -> DONE with timeout=1 at elapsed=50. Assert resetn mid-BLANK -> all outputs at reset values immediately.
